// File: rtl/result_checker.sv
// Store-snooping result checker: compares core stores in a small result window
// against a fixed golden table and reports a sticky PASS/FAIL verdict with diagnostics.
module result_checker #(
   parameter logic [31:0] BASE_ADDR = 32'd200,
   parameter int unsigned TIMEOUT   = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic        Done,
   output logic        Pass,
   output logic        Fail,
   output logic [3:0]  FailCode,
   output logic [31:0] FailData,
   output logic [3:0]  WriteCount
);

   localparam logic [31:0] WIN_SPAN = 32'd32;
   localparam int          WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
   localparam bit          WD_ON    = (TIMEOUT != 0);

   localparam logic [3:0]  CODE_ADDR    = 4'd14;
   localparam logic [3:0]  CODE_TIMEOUT = 4'd15;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PASS = 2'd1,
      ST_FAIL = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [3:0]        code_nxt;
   logic [31:0]       data_nxt;
   logic [3:0]        count_nxt;
   logic [WD_W-1:0]   wd, wd_nxt;

   logic [31:0]       offset;
   logic [3:0]        idx;
   logic              in_window;
   logic              match;
   logic              terminal;
   logic              wd_expire;

   function automatic logic [31:0] golden(input logic [3:0] i);
      case (i)
         4'd0:    golden = 32'h4585E600;
         4'd1:    golden = 32'h45C8C700;
         4'd2:    golden = 32'h9C66BC00;
         4'd3:    golden = 32'h40000000;
         4'd4:    golden = 32'h0BCC6700;
         4'd5:    golden = 32'h40000000;
         4'd6:    golden = 32'h00004040;
         4'd7:    golden = 32'h00003A80;
         4'd8:    golden = 32'h00000000;
         default: golden = 32'h00000000;
      endcase
   endfunction

   // Address decode: unsigned window test (no wrap below BASE_ADDR) and golden compare
   always_comb begin
      offset    = Adr - BASE_ADDR;
      idx       = offset[5:2];
      in_window = (Adr >= BASE_ADDR) && (offset <= WIN_SPAN) && (Adr[1:0] == 2'b00);
      match     = in_window && (WriteData == golden(idx));
      terminal  = (idx == 4'd7) || (idx == 4'd8);
      wd_expire = WD_ON && (wd == WD_MAX);
   end

   // Next-state and diagnostic update; a store always outranks the watchdog
   always_comb begin
      state_nxt = state;
      code_nxt  = FailCode;
      data_nxt  = FailData;
      count_nxt = WriteCount;
      wd_nxt    = wd;
      case (state)
         ST_RUN: begin
            if (MemWrite) begin
               if (!in_window) begin
                  state_nxt = ST_FAIL;
                  code_nxt  = CODE_ADDR;
                  data_nxt  = WriteData;
               end else if (!match) begin
                  state_nxt = ST_FAIL;
                  code_nxt  = idx;
                  data_nxt  = WriteData;
               end else begin
                  count_nxt = (WriteCount == 4'd15) ? 4'd15 : (WriteCount + 4'd1);
                  wd_nxt    = '0;
                  if (terminal) begin
                     state_nxt = ST_PASS;
                  end else begin
                     state_nxt = ST_RUN;
                  end
               end
            end else if (wd_expire) begin
               state_nxt = ST_FAIL;
               code_nxt  = CODE_TIMEOUT;
               data_nxt  = 32'h0000_0000;
            end else if (WD_ON) begin
               wd_nxt = wd + WD_W'(1);
            end else begin
               wd_nxt = '0;
            end
         end
         ST_PASS, ST_FAIL: begin
            state_nxt = state;
         end
         default: begin
            state_nxt = ST_FAIL;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Diagnostic and watchdog registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         FailCode   <= 4'd0;
         FailData   <= 32'h0000_0000;
         WriteCount <= 4'd0;
         wd         <= '0;
      end else begin
         FailCode   <= code_nxt;
         FailData   <= data_nxt;
         WriteCount <= count_nxt;
         wd         <= wd_nxt;
      end
   end

   // Verdict flags decoded from the state register
   always_comb begin
      Pass = (state == ST_PASS);
      Fail = (state == ST_FAIL);
      Done = (state == ST_PASS) || (state == ST_FAIL);
   end

endmodule

// File: tb/tb_result_checker.sv
// Scoreboard bench for result_checker: a behavioural model queues the expected
// outputs for every driven cycle and they are compared once the DUT has clocked.
module tb_result_checker;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] Adr;
   logic [31:0] WriteData;
   logic        Done, Pass, Fail;
   logic [3:0]  FailCode;
   logic [31:0] FailData;
   logic [3:0]  WriteCount;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   result_checker #(.BASE_ADDR(32'd200), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
      .Done(Done), .Pass(Pass), .Fail(Fail), .FailCode(FailCode),
      .FailData(FailData), .WriteCount(WriteCount)
   );

   typedef struct packed {
      logic [2:0]  flags;
      logic [3:0]  code;
      logic [31:0] data;
      logic [3:0]  cnt;
   } exp_t;

   exp_t exp_q[$];

   logic [31:0] gold [0:8] = '{32'h4585E600, 32'h45C8C700, 32'h9C66BC00, 32'h40000000,
                               32'h0BCC6700, 32'h40000000, 32'h00004040, 32'h00003A80,
                               32'h00000000};

   logic        m_pass, m_fail;
   logic [3:0]  m_code;
   logic [31:0] m_data;
   int          m_cnt, m_wd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset;
      m_pass = 1'b0; m_fail = 1'b0; m_code = 4'd0; m_data = 32'd0; m_cnt = 0; m_wd = 0;
   endtask

   task automatic model_step(input logic mw, input logic [31:0] a, input logic [31:0] d);
      int i;
      if (!m_pass && !m_fail) begin
         if (mw) begin
            if (a < 32'd200 || a > 32'd232 || a[1:0] != 2'b00) begin
               m_fail = 1'b1; m_code = 4'd14; m_data = d;
            end else begin
               i = int'((a - 32'd200) / 32'd4);
               if (d != gold[i]) begin
                  m_fail = 1'b1; m_code = 4'(i); m_data = d;
               end else begin
                  if (m_cnt < 15) m_cnt++;
                  m_wd = 0;
                  if (i >= 7) m_pass = 1'b1;
               end
            end
         end else if (m_wd == 15) begin
            m_fail = 1'b1; m_code = 4'd15; m_data = 32'd0;
         end else begin
            m_wd++;
         end
      end
   endtask

   task automatic push_expected;
      exp_t e;
      e.flags = {m_pass | m_fail, m_pass, m_fail};
      e.code  = m_code;
      e.data  = m_data;
      e.cnt   = 4'(m_cnt);
      exp_q.push_back(e);
   endtask

   task automatic pop_compare(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_flags"}, 32'({Done, Pass, Fail}), 32'(e.flags));
         check({tag, "_code"},  32'(FailCode), 32'(e.code));
         check({tag, "_data"},  FailData, e.data);
         check({tag, "_count"}, 32'(WriteCount), 32'(e.cnt));
      end
   endtask

   // One clock: drive at posedge+1, model it, compare just after the edge
   task automatic cycle(input string tag, input logic mw, input logic [31:0] a, input logic [31:0] d);
      MemWrite = mw; Adr = a; WriteData = d;
      model_step(mw, a, d);
      push_expected();
      @(posedge clk); #1;
      MemWrite = 1'b0;
      pop_compare(tag);
   endtask

   task automatic do_reset;
      @(negedge clk);
      reset = 1'b0; MemWrite = 1'b0;
      model_reset();
      push_expected();
      #1;
      pop_compare("reset");
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic run_golden(input string tag);
      for (int i = 0; i < 8; i++) begin
         cycle(tag, 1'b1, 32'd200 + 32'(4 * i), gold[i]);
         cycle(tag, 1'b0, 32'd0, 32'd0);
         cycle(tag, 1'b0, 32'd0, 32'd0);
      end
   endtask

   initial begin
      int first_fail;
      reset = 1'b0; MemWrite = 1'b0; Adr = 32'd0; WriteData = 32'd0;
      model_reset();

      // 1: full golden sequence
      do_reset();
      run_golden("t1");
      check("t1_pass", 32'(Pass), 32'd1);
      check("t1_wcount", 32'(WriteCount), 32'd8);
      check("t1_fail", 32'(Fail), 32'd0);
      cycle("t1_frozen", 1'b1, 32'd236, 32'h1234_5678);

      // 2: data mismatch at index 1, later terminal store ignored
      do_reset();
      cycle("t2", 1'b1, 32'd200, gold[0]);
      cycle("t2", 1'b1, 32'd204, 32'h45C8C701);
      check("t2_code", 32'(FailCode), 32'd1);
      check("t2_data", FailData, 32'h45C8C701);
      cycle("t2", 1'b1, 32'd228, gold[7]);
      check("t2_nopass", 32'(Pass), 32'd0);

      // 3: top-of-window word
      do_reset();
      cycle("t3a", 1'b1, 32'd232, 32'h0000_0008);
      check("t3_code8", 32'(FailCode), 32'd8);
      do_reset();
      cycle("t3b", 1'b1, 32'd232, 32'h0000_0000);
      check("t3_pass", 32'(Pass), 32'd1);
      check("t3_wcount", 32'(WriteCount), 32'd1);

      // 4: below window, misaligned, above window, far wrap-around address
      do_reset();
      cycle("t4a", 1'b1, 32'd196, 32'hAAAA_0001);
      check("t4a_code", 32'(FailCode), 32'd14);
      do_reset();
      cycle("t4b", 1'b1, 32'd202, gold[0]);
      check("t4b_data", FailData, gold[0]);
      do_reset();
      cycle("t4c", 1'b1, 32'd236, 32'h0000_0000);
      do_reset();
      cycle("t4d", 1'b1, 32'hFFFF_FFF8, 32'hDEAD_BEEF);

      // 5: watchdog expiry with no stores
      do_reset();
      first_fail = 0;
      for (int i = 1; i <= 20; i++) begin
         cycle("t5a", 1'b0, 32'd0, 32'd0);
         if (Fail && first_fail == 0) first_fail = i;
      end
      check("t5_timeout_cycle", 32'(first_fail), 32'd16);
      check("t5_code15", 32'(FailCode), 32'd15);

      // 5b: store on the expiry cycle wins, then stores every 10 cycles (count saturates)
      do_reset();
      for (int i = 0; i < 15; i++) cycle("t5b", 1'b0, 32'd0, 32'd0);
      cycle("t5b_edge", 1'b1, 32'd208, gold[2]);
      for (int s = 0; s < 17; s++) begin
         for (int i = 0; i < 9; i++) cycle("t5b", 1'b0, 32'd0, 32'd0);
         cycle("t5b", 1'b1, 32'd200 + 32'(4 * (s % 7)), gold[s % 7]);
      end
      check("t5b_nofail", 32'(Fail), 32'd0);
      check("t5b_sat", 32'(WriteCount), 32'd15);

      // 6: asynchronous reset pulse between edges, then full sequence again
      do_reset();
      for (int i = 0; i < 3; i++) cycle("t6", 1'b1, 32'd200 + 32'(4 * i), gold[i]);
      check("t6_wcount3", 32'(WriteCount), 32'd3);
      reset = 1'b0;
      model_reset();
      push_expected();
      #2;
      pop_compare("t6_async");
      #1;
      reset = 1'b1;
      run_golden("t6_rerun");
      check("t6_pass", 32'(Pass), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
